// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a req/ready handshake with a
// fixed number of wait states, byte-lane stores, extended loads and misalignment flagging.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int ALEN        = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dmem_req_i,
  input  logic [ALEN-1:0] dmem_addr_i,
  input  logic [XLEN-1:0] dmem_wdata_i,
  input  logic            dmem_we_i,
  input  logic [3:0]      dmem_be_i,
  input  logic [2:0]      dmem_funct3_i,
  output logic            dmem_ready_o,
  output logic [XLEN-1:0] dmem_rdata_o,
  output logic            dmem_err_o,
  output logic            dmem_busy_o
);

  localparam int   AW      = $clog2(DEPTH_WORDS);
  localparam logic NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [AW+1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [2:0]      funct3_q;
  logic            ready_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            busy_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic [AW+1:0]   acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic            acc_we;
  logic [3:0]      acc_be;
  logic [2:0]      acc_f3;
  logic [AW-1:0]   acc_idx;
  logic            enter_resp;
  logic            wr_en;
  logic            err_d;
  logic [XLEN-1:0] rdata_d;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] rd_shift;
  logic [15:0]     rd_half;
  logic            unused_addr;

  assign unused_addr = ^dmem_addr_i[ALEN-1:AW+2];

  // With zero wait states the RAM access happens on the accepting edge, so the
  // live request is used; otherwise the latched copy is.
  always_comb begin
    acc_addr   = (state_q == IDLE) ? dmem_addr_i[AW+1:0] : addr_q;
    acc_wdata  = (state_q == IDLE) ? dmem_wdata_i        : wdata_q;
    acc_we     = (state_q == IDLE) ? dmem_we_i           : we_q;
    acc_be     = (state_q == IDLE) ? dmem_be_i           : be_q;
    acc_f3     = (state_q == IDLE) ? dmem_funct3_i       : funct3_q;
    acc_idx    = acc_addr[AW+1:2];
    enter_resp = ((state_q == IDLE) && dmem_req_i && NO_WAIT) ||
                 ((state_q == WAIT) && (cnt_q <= 4'd1));

    err_d = (acc_f3[1:0] == 2'b11) || (acc_f3[2] && (acc_we || acc_f3[1])) ||
            ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
            ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    wr_en = enter_resp && acc_we && !err_d;

    case (acc_f3[1:0])
      2'b00:   lane_data = acc_wdata << {acc_addr[1:0], 3'b000};
      2'b01:   lane_data = acc_wdata << {acc_addr[1], 4'b0000};
      default: lane_data = acc_wdata;
    endcase

    rd_word  = mem[acc_idx];
    rd_shift = rd_word >> {acc_addr[1:0], 3'b000};
    rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_f3)
      3'b000:  rdata_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rdata_d = {{16{rd_half[15]}}, rd_half};
      3'b010:  rdata_d = rd_word;
      3'b100:  rdata_d = {24'd0, rd_shift[7:0]};
      3'b101:  rdata_d = {16'd0, rd_half};
      default: rdata_d = '0;
    endcase
    if (acc_we || err_d) begin
      rdata_d = '0;
    end
  end

  // RAM is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      funct3_q <= 3'd0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= enter_resp;
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
      case (state_q)
        IDLE: begin
          if (dmem_req_i) begin
            addr_q   <= dmem_addr_i[AW+1:0];
            wdata_q  <= dmem_wdata_i;
            we_q     <= dmem_we_i;
            be_q     <= dmem_be_i;
            funct3_q <= dmem_funct3_i;
            cnt_q    <= 4'(WAIT_STATES);
            busy_q   <= 1'b1;
            state_q  <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_ready_o = ready_q;
  assign dmem_rdata_o = rdata_q;
  assign dmem_err_o   = err_q;
  assign dmem_busy_o  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (0, 1 and 3 wait states)
// checked against a byte-level memory model with random and directed accesses.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [2:0]  f3 = 3'd0;

  wire  [2:0]  readyV;
  wire  [2:0]  errV;
  wire  [2:0]  busyV;
  wire  [31:0] rdataV [3];

  logic [31:0] modelMem [DEPTH];
  exp_t        sb [$];
  int          busyLo [3] = '{default: 0};
  int          busyHi [3] = '{default: -1};
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .dmem_req_i(req[0]), .dmem_addr_i(addr),
    .dmem_wdata_i(wdata), .dmem_we_i(we), .dmem_be_i(be), .dmem_funct3_i(f3),
    .dmem_ready_o(readyV[0]), .dmem_rdata_o(rdataV[0]), .dmem_err_o(errV[0]),
    .dmem_busy_o(busyV[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .dmem_req_i(req[1]), .dmem_addr_i(addr),
    .dmem_wdata_i(wdata), .dmem_we_i(we), .dmem_be_i(be), .dmem_funct3_i(f3),
    .dmem_ready_o(readyV[1]), .dmem_rdata_o(rdataV[1]), .dmem_err_o(errV[1]),
    .dmem_busy_o(busyV[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .dmem_req_i(req[2]), .dmem_addr_i(addr),
    .dmem_wdata_i(wdata), .dmem_we_i(we), .dmem_be_i(be), .dmem_funct3_i(f3),
    .dmem_ready_o(readyV[2]), .dmem_rdata_o(rdataV[2]), .dmem_err_o(errV[2]),
    .dmem_busy_o(busyV[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waitsOf(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, bytes moved by plain arithmetic.
  task automatic modelAccess(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic [2:0] f,
                             output logic [31:0] rd, output logic e);
    int          idx;
    int          off;
    int          size;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] msk;
    logic [31:0] v;
    idx  = int'(a >> 2) % DEPTH;
    off  = int'(a % 4);
    size = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
    e    = (f[1:0] == 2'b11) || (w && f[2]) || (!w && f == 3'b110) || (off % size != 0);
    rd   = 32'd0;
    if (e) return;
    word = modelMem[idx];
    if (w) begin
      shifted = d << (8 * off);
      for (int i = 0; i < 4; i++)
        if (b[i]) word[8*i +: 8] = shifted[8*i +: 8];
      modelMem[idx] = word;
    end else begin
      msk = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v   = (word >> (8 * off)) & msk;
      if (!f[2] && size < 4 && v[8*size-1]) v = v | ~msk;
      rd = v;
    end
  endtask

  // Issues one access to the instances in mask; toggle wiggles req/addr of the
  // 3-wait-state instance while it is still waiting.
  task automatic applyStimulus(input logic [2:0] mask, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b, input logic [2:0] f,
                               input bit useExp, input logic [31:0] expD, input logic expE,
                               input bit toggle);
    logic [31:0] md;
    logic        me;
    exp_t        e;
    @(negedge clk);
    modelAccess(w, a, d, b, f, md, me);
    if (useExp) begin
      md = expD;
      me = expE;
    end
    addr = a; wdata = d; we = w; be = b; f3 = f; req = mask;
    for (int k = 0; k < 3; k++) begin
      if (mask[k]) begin
        e.dut = k; e.rdata = md; e.err = me; e.cyc = cyc + 1 + waitsOf(k);
        sb.push_back(e);
        busyLo[k] = cyc + 1;
        busyHi[k] = cyc + 1 + waitsOf(k);
      end
    end
    @(negedge clk);
    if (toggle) begin
      req = 3'b100; addr = ~a; we = ~w; f3 = 3'b010; be = 4'hF; wdata = ~d;
      @(negedge clk);
      req = 3'b000;
      @(negedge clk);
      req = 3'b100;
      @(negedge clk);
    end
    req = 3'b000;
    repeat (5) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int  idx;
    int  n;
    logic expBusy;
    for (int k = 0; k < 3; k++) begin
      expBusy = (cyc >= busyLo[k]) && (cyc <= busyHi[k]);
      checkOutput($sformatf("busy%0d", k), {31'd0, busyV[k]}, {31'd0, expBusy});
      if (readyV[k]) begin
        idx = -1;
        n   = sb.size();
        for (int i = 0; i < n; i++) begin
          if (idx < 0 && sb[i].dut == k) idx = i;
        end
        if (idx < 0) begin
          checkOutput($sformatf("unexpected_ready%0d", k), 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("rdata%0d", k), rdataV[k], sb[idx].rdata);
          checkOutput($sformatf("err%0d", k), {31'd0, errV[k]}, {31'd0, sb[idx].err});
          checkOutput($sformatf("ready_cycle%0d", k), cyc, sb[idx].cyc);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    int          size;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset_ready%0d", k), {31'd0, readyV[k]}, 32'd0);
      checkOutput($sformatf("reset_rdata%0d", k), rdataV[k], 32'd0);
      checkOutput($sformatf("reset_err%0d", k), {31'd0, errV[k]}, 32'd0);
    end
    #2 rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(3'b111, 1'b1, 32'(i * 4), $urandom, 4'hF, 3'b010, 1'b0, 32'd0, 1'b0, 1'b0);

    applyStimulus(3'b111, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 1'b1, 32'd0, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h10, 32'd0, 4'hF, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b1, 32'h13, 32'h000000A5, 4'b1000, 3'b000, 1'b1, 32'd0, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h10, 32'd0, 4'hF, 3'b010, 1'b1, 32'hA5ADBEEF, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h13, 32'd0, 4'h8, 3'b000, 1'b1, 32'hFFFFFFA5, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h13, 32'd0, 4'h8, 3'b100, 1'b1, 32'h000000A5, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b1, 32'h12, 32'h00008001, 4'b1100, 3'b001, 1'b1, 32'd0, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h12, 32'd0, 4'hC, 3'b001, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h12, 32'd0, 4'hC, 3'b101, 1'b1, 32'h00008001, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h11, 32'd0, 4'hF, 3'b010, 1'b1, 32'd0, 1'b1, 1'b0);
    applyStimulus(3'b111, 1'b1, 32'h15, 32'h0000BEEF, 4'b0110, 3'b001, 1'b1, 32'd0, 1'b1, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h14, 32'd0, 4'hF, 3'b010, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b0, 32'h110, 32'd0, 4'hF, 3'b010, 1'b1, 32'h8001BEEF, 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b0, 32'h10, 32'd0, 4'hF, 3'b010, 1'b1, 32'h8001BEEF, 1'b0, 1'b1);

    // Reset lands while the 3-wait-state store is still waiting.
    @(negedge clk);
    addr = 32'h20; wdata = 32'h12345678; we = 1'b1; be = 4'hF; f3 = 3'b010; req = 3'b100;
    busyLo[2] = cyc + 1;
    busyHi[2] = cyc + 4;
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    busyHi[2] = -1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("midreset_ready%0d", k), {31'd0, readyV[k]}, 32'd0);
      checkOutput($sformatf("midreset_rdata%0d", k), rdataV[k], 32'd0);
      checkOutput($sformatf("midreset_busy%0d", k), {31'd0, busyV[k]}, 32'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(3'b111, 1'b0, 32'h20, 32'd0, 4'hF, 3'b010, 1'b0, 32'd0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      w    = 1'($urandom_range(0, 1));
      f    = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a    = $urandom;
      size = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size - 1);
      applyStimulus(3'b111, w, a, $urandom, 4'(((1 << size) - 1) << (a % 4)), f,
                    1'b0, 32'd0, 1'b0, 1'b0);
    end

    repeat (10) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
